// File: rtl/mm_seg_display.sv
// Four-digit multiplexed seven-segment driver for a BCD voltage reading (0.00..9.99 style).
// Captures BCD updates, blanks leading zeros above the decimal point, and shows dashes when stale.
module mm_seg_display #(
  parameter int unsigned REFRESH_DIV  = 50000,
  parameter int unsigned GUARD_CYCLES = 16,
  parameter int unsigned DP_POS       = 2,
  parameter int unsigned STALE_CYCLES = 100000000,
  parameter bit          ACTIVE_LOW   = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr_i,
  input  logic [15:0] din_bcd_i,
  input  logic        din_update_i,
  input  logic        hold_i,
  output logic [3:0]  an_o,
  output logic [6:0]  seg_o,
  output logic        dp_o,
  output logic        stale_o
);

  localparam int unsigned SlotW  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned StaleW = $clog2(STALE_CYCLES + 1);
  localparam logic [SlotW-1:0]  SlotMax  = SlotW'(REFRESH_DIV - 1);
  localparam logic [SlotW-1:0]  GuardEnd = SlotW'(GUARD_CYCLES);
  localparam logic [StaleW-1:0] StaleMax = StaleW'(STALE_CYCLES - 1);

  logic [15:0]       value_q, value_d;
  logic [SlotW-1:0]  slot_q, slot_d;
  logic [1:0]        idx_q, idx_d;
  logic [StaleW-1:0] stale_cnt_q, stale_cnt_d;
  logic              stale_q, stale_d;
  logic [3:0]        an_q, an_d;
  logic [6:0]        seg_q, seg_d;
  logic              dp_q, dp_d;

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'h3F;
      4'd1:    decode = 7'h06;
      4'd2:    decode = 7'h5B;
      4'd3:    decode = 7'h4F;
      4'd4:    decode = 7'h66;
      4'd5:    decode = 7'h6D;
      4'd6:    decode = 7'h7D;
      4'd7:    decode = 7'h07;
      4'd8:    decode = 7'h7F;
      4'd9:    decode = 7'h6F;
      default: decode = 7'h40;
    endcase
  endfunction

  logic       accept;
  logic       guard;
  logic       blank;
  logic [3:0] lz;
  logic [3:0] nib;
  logic [3:0] an_act;
  logic [6:0] seg_act;
  logic       dp_act;

  always_comb begin
    accept = din_update_i && !hold_i && !clr_i;

    value_d     = value_q;
    stale_cnt_d = stale_cnt_q;
    stale_d     = stale_q;
    if (clr_i) begin
      value_d     = '0;
      stale_cnt_d = '0;
      stale_d     = 1'b0;
    end else if (hold_i) begin
      // Held: value and stale timer both frozen.
      stale_cnt_d = stale_cnt_q;
    end else if (accept) begin
      value_d     = din_bcd_i;
      stale_cnt_d = '0;
      stale_d     = 1'b0;
    end else if (stale_cnt_q == StaleMax) begin
      stale_d = 1'b1;
    end else begin
      stale_cnt_d = stale_cnt_q + 1'b1;
    end

    if (slot_q == SlotMax) begin
      slot_d = '0;
      idx_d  = idx_q + 2'd1;
    end else begin
      slot_d = slot_q + 1'b1;
      idx_d  = idx_q;
    end

    // lz[k]: nibble k and every nibble above it are zero.
    lz[3] = (value_q[15:12] == 4'd0);
    lz[2] = lz[3] && (value_q[11:8] == 4'd0);
    lz[1] = lz[2] && (value_q[7:4] == 4'd0);
    lz[0] = lz[1] && (value_q[3:0] == 4'd0);

    nib   = value_q[{idx_q, 2'b00} +: 4];
    blank = (32'(idx_q) > DP_POS) && lz[idx_q];
    guard = (slot_q < GuardEnd);

    an_act  = guard ? 4'b0000 : (4'b0001 << idx_q);
    seg_act = stale_q ? 7'h40 : (blank ? 7'h00 : decode(nib));
    dp_act  = (32'(idx_q) == DP_POS) && !stale_q && !guard;

    an_d  = ACTIVE_LOW ? ~an_act : an_act;
    seg_d = ACTIVE_LOW ? ~seg_act : seg_act;
    dp_d  = ACTIVE_LOW ? ~dp_act : dp_act;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      value_q     <= '0;
      slot_q      <= '0;
      idx_q       <= '0;
      stale_cnt_q <= '0;
      stale_q     <= 1'b0;
      an_q        <= ACTIVE_LOW ? 4'hF : 4'h0;
      seg_q       <= ACTIVE_LOW ? 7'h7F : 7'h00;
      dp_q        <= ACTIVE_LOW;
    end else begin
      value_q     <= value_d;
      slot_q      <= slot_d;
      idx_q       <= idx_d;
      stale_cnt_q <= stale_cnt_d;
      stale_q     <= stale_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
    end
  end

  assign an_o    = an_q;
  assign seg_o   = seg_q;
  assign dp_o    = dp_q;
  assign stale_o = stale_q;

endmodule

// File: tb/tb_mm_seg_display.sv
// Directed bench for mm_seg_display with a short refresh slot and stale timeout.
module tb_mm_seg_display;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr_i = 1'b0;
  logic [15:0] din_bcd_i = '0;
  logic        din_update_i = 1'b0;
  logic        hold_i = 1'b0;
  logic [3:0]  an_o;
  logic [6:0]  seg_o;
  logic        dp_o;
  logic        stale_o;

  int nvec = 0;
  int nfail = 0;

  mm_seg_display #(
    .REFRESH_DIV (8),
    .GUARD_CYCLES(2),
    .DP_POS      (2),
    .STALE_CYCLES(100),
    .ACTIVE_LOW  (1'b1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .clr_i       (clr_i),
    .din_bcd_i   (din_bcd_i),
    .din_update_i(din_update_i),
    .hold_i      (hold_i),
    .an_o        (an_o),
    .seg_o       (seg_o),
    .dp_o        (dp_o),
    .stale_o     (stale_o)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Bounded wait for digit k to be the active anode (active-low).
  task automatic wait_an(input int k, output bit ok);
    logic [3:0] want;
    want = ~(4'b0001 << k);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (an_o === want) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic capture(input logic [15:0] v);
    din_bcd_i    = v;
    din_update_i = 1'b1;
    tick();
    din_update_i = 1'b0;
    tick();
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick();
    nvec++;
    if (an_o !== 4'hF || seg_o !== 7'h7F || dp_o !== 1'b1 || stale_o !== 1'b0) begin
      nfail++;
      $display("FAIL reset: an=%h seg=%h dp=%b stale=%b, want an=f seg=7f dp=1 stale=0",
               an_o, seg_o, dp_o, stale_o);
    end
    rst = 1'b0;
    tick(2);
    nvec++;
    if (an_o !== 4'hF) begin
      nfail++;
      $display("FAIL reset_guard: an=%h want f", an_o);
    end
    tick();
    nvec++;
    if (an_o !== 4'hE) begin
      nfail++;
      $display("FAIL reset_first_digit: an=%h want e", an_o);
    end
  endtask

  task automatic test_show_330;
    logic [6:0] es [4] = '{7'h40, 7'h30, 7'h30, 7'h7F};
    logic       ed [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    bit ok;
    int n;
    capture(16'h0330);
    for (int k = 0; k < 4; k++) begin
      wait_an(k, ok);
      nvec++;
      if (!ok || seg_o !== es[k] || dp_o !== ed[k]) begin
        nfail++;
        $display("FAIL show_330 d%0d: found=%b seg=%h dp=%b, want seg=%h dp=%b",
                 k, ok, seg_o, dp_o, es[k], ed[k]);
      end
    end
    // Count the all-off run at the next slot start.
    n = 0;
    for (int i = 0; i < 20 && an_o !== 4'hF; i++) tick();
    for (int i = 0; i < 20 && an_o === 4'hF; i++) begin
      n++;
      tick();
    end
    nvec++;
    if (n != 2) begin
      nfail++;
      $display("FAIL guard_len: got %0d all-off cycles, want 2", n);
    end
  endtask

  task automatic test_show_zero;
    logic [6:0] es [4] = '{7'h40, 7'h40, 7'h40, 7'h7F};
    logic       ed [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    bit ok;
    capture(16'h0000);
    for (int k = 0; k < 4; k++) begin
      wait_an(k, ok);
      nvec++;
      if (!ok || seg_o !== es[k] || dp_o !== ed[k]) begin
        nfail++;
        $display("FAIL show_zero d%0d: found=%b seg=%h dp=%b, want seg=%h dp=%b",
                 k, ok, seg_o, dp_o, es[k], ed[k]);
      end
    end
  endtask

  task automatic test_stale;
    logic [6:0] es [4] = '{7'h30, 7'h24, 7'h79, 7'h7F};
    logic       ed [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    bit ok;
    capture(16'h0000);
    tick(50);
    nvec++;
    if (stale_o !== 1'b0) begin
      nfail++;
      $display("FAIL stale_early: stale=%b want 0", stale_o);
    end
    tick(55);
    nvec++;
    if (stale_o !== 1'b1) begin
      nfail++;
      $display("FAIL stale_set: stale=%b want 1", stale_o);
    end
    for (int k = 0; k < 4; k += 2) begin
      wait_an(k, ok);
      nvec++;
      if (!ok || seg_o !== 7'h3F || dp_o !== 1'b1) begin
        nfail++;
        $display("FAIL stale_dash d%0d: found=%b seg=%h dp=%b, want seg=3f dp=1",
                 k, ok, seg_o, dp_o);
      end
    end
    din_bcd_i    = 16'h0123;
    din_update_i = 1'b1;
    tick();
    din_update_i = 1'b0;
    nvec++;
    if (stale_o !== 1'b0) begin
      nfail++;
      $display("FAIL stale_clear: stale=%b want 0", stale_o);
    end
    tick();
    for (int k = 0; k < 4; k++) begin
      wait_an(k, ok);
      nvec++;
      if (!ok || seg_o !== es[k] || dp_o !== ed[k]) begin
        nfail++;
        $display("FAIL show_123 d%0d: found=%b seg=%h dp=%b, want seg=%h dp=%b",
                 k, ok, seg_o, dp_o, es[k], ed[k]);
      end
    end
  endtask

  task automatic test_hold;
    logic [6:0] es [4] = '{7'h40, 7'h40, 7'h79, 7'h7F};
    bit ok;
    capture(16'h0100);
    tick(59);
    hold_i       = 1'b1;
    din_bcd_i    = 16'h0250;
    din_update_i = 1'b1;
    tick();
    din_update_i = 1'b0;
    tick(200);
    nvec++;
    if (stale_o !== 1'b0) begin
      nfail++;
      $display("FAIL hold_stale: stale=%b want 0", stale_o);
    end
    for (int k = 0; k < 4; k++) begin
      wait_an(k, ok);
      nvec++;
      if (!ok || seg_o !== es[k]) begin
        nfail++;
        $display("FAIL hold_show d%0d: found=%b seg=%h, want %h", k, ok, seg_o, es[k]);
      end
    end
    hold_i = 1'b0;
    tick(30);
    nvec++;
    if (stale_o !== 1'b0) begin
      nfail++;
      $display("FAIL hold_resume_early: stale=%b want 0", stale_o);
    end
    tick(15);
    nvec++;
    if (stale_o !== 1'b1) begin
      nfail++;
      $display("FAIL hold_resume: stale=%b want 1 (counter should resume)", stale_o);
    end
  endtask

  task automatic test_clear;
    logic [6:0] es [4] = '{7'h40, 7'h40, 7'h40, 7'h7F};
    logic       ed [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    bit ok;
    din_bcd_i    = 16'h0999;
    din_update_i = 1'b1;
    clr_i        = 1'b1;
    tick();
    din_update_i = 1'b0;
    clr_i        = 1'b0;
    nvec++;
    if (stale_o !== 1'b0) begin
      nfail++;
      $display("FAIL clear_stale: stale=%b want 0", stale_o);
    end
    tick();
    for (int k = 0; k < 4; k++) begin
      wait_an(k, ok);
      nvec++;
      if (!ok || seg_o !== es[k] || dp_o !== ed[k]) begin
        nfail++;
        $display("FAIL clear_show d%0d: found=%b seg=%h dp=%b, want seg=%h dp=%b",
                 k, ok, seg_o, dp_o, es[k], ed[k]);
      end
    end
  endtask

  task automatic test_dash_and_reset;
    logic [6:0] es [4] = '{7'h12, 7'h40, 7'h3F, 7'h7F};
    logic       ed [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    bit ok;
    capture(16'h0A05);
    for (int k = 0; k < 4; k++) begin
      wait_an(k, ok);
      nvec++;
      if (!ok || seg_o !== es[k] || dp_o !== ed[k]) begin
        nfail++;
        $display("FAIL dash d%0d: found=%b seg=%h dp=%b, want seg=%h dp=%b",
                 k, ok, seg_o, dp_o, es[k], ed[k]);
      end
    end
    wait_an(1, ok);
    tick();
    rst = 1'b1;
    tick();
    nvec++;
    if (an_o !== 4'hF || seg_o !== 7'h7F || dp_o !== 1'b1) begin
      nfail++;
      $display("FAIL midreset: an=%h seg=%h dp=%b, want f 7f 1", an_o, seg_o, dp_o);
    end
    rst = 1'b0;
    tick(2);
    nvec++;
    if (an_o !== 4'hF) begin
      nfail++;
      $display("FAIL midreset_guard: an=%h want f", an_o);
    end
    tick();
    nvec++;
    if (an_o !== 4'hE || seg_o !== 7'h40) begin
      nfail++;
      $display("FAIL midreset_restart: an=%h seg=%h, want e 40", an_o, seg_o);
    end
  endtask

  initial begin
    test_reset();
    test_show_330();
    test_show_zero();
    test_stale();
    test_hold();
    test_clear();
    test_dash_and_reset();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
